fb_arbiter: RTL and testbench

Single-port frame-buffer arbiter sharing one synchronous SRAM between the BT656 camera write path and the VGA pixel read path. Decides one access per clock, gives VGA reads priority to meet scan-out deadlines, and drives the memory with registered strobes. Returns read data to the VGA side through a fixed-latency pipeline. An optional starvation guard ensures camera writes still progress during long read bursts.

---
 rtl/fb_arb_pkg.sv | 16 +
 rtl/fb_arb_if.sv | 41 ++++
 rtl/fb_arb_rd_pipe.sv | 40 ++++
 rtl/fb_arbiter.sv | 92 +++++++++
 tb/tb_fb_arbiter.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/fb_arb_pkg.sv
// fb_arb_pkg: shared defaults and the grant-select encoding for the
// frame-buffer arbiter.
package fb_arb_pkg;

  localparam int ADDR_W_DEF     = 19;
  localparam int DATA_W_DEF     = 16;
  localparam int RD_LAT_DEF     = 2;
  localparam int MAX_CONSEC_DEF = 8;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_VGA,
    GNT_CAM
  } gnt_t;

endpackage

// File: rtl/fb_arb_if.sv
// fb_arb_if: bundles the VGA read port, camera write port and SRAM port
// of the frame-buffer arbiter. The slave view belongs to the arbiter. The
// master view belongs to the requesters and the memory.
interface fb_arb_if
  import fb_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_gnt;
  logic              vga_rvalid;
  logic [DATA_W-1:0] vga_rdata;

  logic              cam_req;
  logic [ADDR_W-1:0] cam_addr;
  logic [DATA_W-1:0] cam_wdata;
  logic              cam_gnt;
  logic              cam_stall;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  vga_req, vga_addr, cam_req, cam_addr, cam_wdata, mem_rdata,
    output vga_gnt, vga_rvalid, vga_rdata, cam_gnt, cam_stall,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output vga_req, vga_addr, cam_req, cam_addr, cam_wdata, mem_rdata,
    input  vga_gnt, vga_rvalid, vga_rdata, cam_gnt, cam_stall,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/fb_arb_rd_pipe.sv
// fb_arb_rd_pipe: the read-return path. A valid tag follows each VGA grant
// through RD_LAT+1 stages. The tag lines up with mem_rdata, and the data is
// then registered once more onto the VGA side. Reset clears every tag, so
// reads still in flight produce no pulse.
module fb_arb_rd_pipe
  import fb_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gnt,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata
);

  // Stage 0 lines up with the registered mem_en strobe. Stage RD_LAT lines
  // up with valid mem_rdata.
  logic [RD_LAT:0] vld_p;

  // Shift the grant tag along with the memory access latency.
  always_ff @(posedge clk) begin
    if (reset) vld_p <= '0;
    else       vld_p <= {vld_p[RD_LAT-1:0], gnt};
  end

  // Capture returning data in the cycle its tag matures.
  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= vld_p[RD_LAT];
      if (vld_p[RD_LAT]) rdata <= mem_rdata;
    end
  end

endmodule

// File: rtl/fb_arbiter.sv
// fb_arbiter: shares one synchronous SRAM between the camera write path and
// the VGA read path. Each cycle it makes at most one grant, and VGA wins by
// default. The SRAM strobes are registered, and read data comes back through
// a fixed-latency pipe.
// Build option: define FB_ARB_STARVE_GUARD_EN to enable the starvation
// guard. With the guard on, the camera is granted once it has waited
// through MAX_CONSEC VGA grants.
module fb_arbiter
  import fb_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RD_LAT     = RD_LAT_DEF,
  parameter int MAX_CONSEC = MAX_CONSEC_DEF
) (
  input logic   clk,
  input logic   reset,
  fb_arb_if.slave bus
);

  gnt_t sel;
  logic vga_gnt;
  logic cam_gnt;
  logic cam_force;

`ifdef FB_ARB_STARVE_GUARD_EN
  logic [7:0] consec;

  assign cam_force = bus.cam_req && (consec == 8'(MAX_CONSEC));

  // Count VGA grants taken while the camera is waiting. The count restarts
  // when the camera is served or stops asking.
  always_ff @(posedge clk) begin
    if (reset)                        consec <= '0;
    else if (cam_gnt || !bus.cam_req) consec <= '0;
    else if (vga_gnt)                 consec <= consec + 8'd1;
  end
`else
  assign cam_force = 1'b0;
`endif

  // Pick one requester. VGA has priority unless the guard forces the camera.
  // Nothing is granted while reset is high.
  always_comb begin
    sel = GNT_NONE;
    if (!reset) begin
      if (bus.cam_req && (cam_force || !bus.vga_req)) sel = GNT_CAM;
      else if (bus.vga_req)                           sel = GNT_VGA;
    end
  end

  assign vga_gnt       = (sel == GNT_VGA);
  assign cam_gnt       = (sel == GNT_CAM);
  assign bus.vga_gnt   = vga_gnt;
  assign bus.cam_gnt   = cam_gnt;
  assign bus.cam_stall = bus.cam_req && !cam_gnt && !reset;

  // Register the granted access onto the SRAM port. Write data keeps its
  // last value during reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.mem_en <= (sel != GNT_NONE);
      bus.mem_we <= (sel == GNT_CAM);
      case (sel)
        GNT_VGA: bus.mem_addr <= bus.vga_addr;
        GNT_CAM: begin
          bus.mem_addr  <= bus.cam_addr;
          bus.mem_wdata <= bus.cam_wdata;
        end
        default: ;
      endcase
    end
  end

  fb_arb_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .reset     (reset),
    .gnt       (vga_gnt),
    .mem_rdata (bus.mem_rdata),
    .rvalid    (bus.vga_rvalid),
    .rdata     (bus.vga_rdata)
  );

endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: directed bench for fb_arbiter with RD_LAT=2 and
// MAX_CONSEC=8. The SRAM model samples mem_en at a clock edge and returns
// the data two edges later. The model reloads addresses 0..3 with
// 0xA000..0xA003 during reset.
module tb_fb_arbiter;
  import fb_arb_pkg::*;

  localparam int AW = 19;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fb_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  fb_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .RD_LAT     (2),
    .MAX_CONSEC (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // SRAM model: a write lands at the sampling edge. A read is returned
  // RD_LAT edges after mem_en.
  logic [DW-1:0] mem [0:255];
  logic          rd_en1 = 1'b0;
  logic [7:0]    rd_addr1 = '0;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= (i < 4) ? 16'(32'hA000 + i) : '0;
    end else if (bus.mem_en && bus.mem_we) begin
      mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end
    rd_en1        <= bus.mem_en && !bus.mem_we;
    rd_addr1      <= bus.mem_addr[7:0];
    bus.mem_rdata <= rd_en1 ? mem[rd_addr1] : '0;
  end

  // Count read-return pulses and keep the most recent returned word.
  int            rv_cnt = 0;
  logic [DW-1:0] rv_last = '0;
  always @(negedge clk) begin
    if (bus.vga_rvalid) begin
      rv_cnt  <= rv_cnt + 1;
      rv_last <= bus.vga_rdata;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then settle before checking.
  task automatic cyc(input logic rs, input logic vr, input logic [AW-1:0] va,
                     input logic cr, input logic [AW-1:0] ca, input logic [DW-1:0] cw);
    @(negedge clk);
    reset         = rs;
    bus.vga_req   = vr;
    bus.vga_addr  = va;
    bus.cam_req   = cr;
    bus.cam_addr  = ca;
    bus.cam_wdata = cw;
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, '0, 1'b0, '0, '0);
  endtask

  int  rv_snap;
  logic exp_cam;
  logic vr;

  initial begin
    bus.vga_req   = 1'b0;
    bus.vga_addr  = '0;
    bus.cam_req   = 1'b0;
    bus.cam_addr  = '0;
    bus.cam_wdata = '0;

    // Reset: grants are forced low and every registered output is zero.
    cyc(1'b1, 1'b1, '0, 1'b1, '0, '0);
    chk1("rst_vga_gnt", bus.vga_gnt, 1'b0);
    chk1("rst_cam_gnt", bus.cam_gnt, 1'b0);
    chk1("rst_cam_stall", bus.cam_stall, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b0, '0, '0);
    chk1("rst_mem_en", bus.mem_en, 1'b0);
    chk1("rst_mem_we", bus.mem_we, 1'b0);
    chkw("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chkw("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    chk1("rst_rvalid", bus.vga_rvalid, 1'b0);
    chkw("rst_rdata", 32'(bus.vga_rdata), 32'd0);

    // Back-to-back VGA reads of addresses 0..3. The data returns 4 cycles after each grant.
    cyc(1'b0, 1'b1, 19'd0, 1'b0, '0, '0);
    chk1("t1_gnt0", bus.vga_gnt, 1'b1);
    chk1("t1_cam_gnt0", bus.cam_gnt, 1'b0);
    cyc(1'b0, 1'b1, 19'd1, 1'b0, '0, '0);
    chk1("t1_gnt1", bus.vga_gnt, 1'b1);
    chk1("t1_mem_en", bus.mem_en, 1'b1);
    chk1("t1_mem_we", bus.mem_we, 1'b0);
    chkw("t1_mem_addr0", 32'(bus.mem_addr), 32'd0);
    cyc(1'b0, 1'b1, 19'd2, 1'b0, '0, '0);
    chkw("t1_mem_addr1", 32'(bus.mem_addr), 32'd1);
    cyc(1'b0, 1'b1, 19'd3, 1'b0, '0, '0);
    chkw("t1_mem_addr2", 32'(bus.mem_addr), 32'd2);
    chk1("t1_rvalid_early", bus.vga_rvalid, 1'b0);
    idle();
    chk1("t1_gnt_idle", bus.vga_gnt, 1'b0);
    chkw("t1_mem_addr3", 32'(bus.mem_addr), 32'd3);
    chk1("t1_rvalid0", bus.vga_rvalid, 1'b1);
    chkw("t1_rdata0", 32'(bus.vga_rdata), 32'hA000);
    for (int k = 1; k < 4; k++) begin
      idle();
      chk1("t1_rvalid", bus.vga_rvalid, 1'b1);
      chkw("t1_rdata", 32'(bus.vga_rdata), 32'hA000 + 32'(k));
    end
    idle();
    chk1("t1_rvalid_end", bus.vga_rvalid, 1'b0);
    chk1("t1_mem_en_end", bus.mem_en, 1'b0);

    // Camera write 0x1234 to address 5, then read it back.
    cyc(1'b0, 1'b0, '0, 1'b1, 19'd5, 16'h1234);
    chk1("t2_cam_gnt", bus.cam_gnt, 1'b1);
    chk1("t2_vga_gnt", bus.vga_gnt, 1'b0);
    chk1("t2_cam_stall", bus.cam_stall, 1'b0);
    idle();
    chk1("t2_mem_en", bus.mem_en, 1'b1);
    chk1("t2_mem_we", bus.mem_we, 1'b1);
    chkw("t2_mem_addr", 32'(bus.mem_addr), 32'd5);
    chkw("t2_mem_wdata", 32'(bus.mem_wdata), 32'h1234);
    cyc(1'b0, 1'b1, 19'd5, 1'b0, '0, '0);
    chk1("t2_rd_gnt", bus.vga_gnt, 1'b1);
    idle();
    chk1("t2_rd_we", bus.mem_we, 1'b0);
    chkw("t2_rd_addr", 32'(bus.mem_addr), 32'd5);
    chkw("t2_wdata_hold", 32'(bus.mem_wdata), 32'h1234);
    idle();
    idle();
    idle();
    chk1("t2_rvalid", bus.vga_rvalid, 1'b1);
    chkw("t2_rdata", 32'(bus.vga_rdata), 32'h1234);

    // Both ports request continuously for 18 cycles.
    for (int i = 0; i < 18; i++) begin
      cyc(1'b0, 1'b1, AW'(i), 1'b1, 19'd100, 16'hBEEF);
`ifdef FB_ARB_STARVE_GUARD_EN
      exp_cam = ((i % 9) == 8);
`else
      exp_cam = 1'b0;
`endif
      chk1("t3_vga_gnt", bus.vga_gnt, !exp_cam);
      chk1("t3_cam_gnt", bus.cam_gnt, exp_cam);
      chk1("t3_cam_stall", bus.cam_stall, !exp_cam);
    end
    for (int i = 0; i < 6; i++) idle();

    // Assert reset in the cycle after three VGA grants. The reads still in flight are dropped.
    cyc(1'b0, 1'b1, 19'd0, 1'b0, '0, '0);
    cyc(1'b0, 1'b1, 19'd1, 1'b0, '0, '0);
    cyc(1'b0, 1'b1, 19'd2, 1'b0, '0, '0);
    cyc(1'b1, 1'b1, 19'd3, 1'b0, '0, '0);
    chk1("t5_gnt_in_reset", bus.vga_gnt, 1'b0);
    idle();
    chk1("t5_mem_en", bus.mem_en, 1'b0);
    chk1("t5_mem_we", bus.mem_we, 1'b0);
    chkw("t5_mem_addr", 32'(bus.mem_addr), 32'd0);
    chkw("t5_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    chk1("t5_rvalid", bus.vga_rvalid, 1'b0);
    chkw("t5_rdata", 32'(bus.vga_rdata), 32'd0);
    rv_snap = rv_cnt;
    for (int i = 0; i < 5; i++) idle();
    chkw("t5_no_rvalid", 32'(rv_cnt - rv_snap), 32'd0);

    // VGA and camera requests alternate each cycle, starting with VGA.
    rv_snap = rv_cnt;
    for (int i = 0; i < 8; i++) begin
      vr = ((i % 2) == 0);
      cyc(1'b0, vr, AW'(i / 2), !vr, AW'(200 + i), 16'(32'h5000 + i));
      chk1("t6_vga_gnt", bus.vga_gnt, vr);
      chk1("t6_cam_gnt", bus.cam_gnt, !vr);
      chk1("t6_not_both", bus.vga_gnt & bus.cam_gnt, 1'b0);
      if (i > 0) chk1("t6_mem_we", bus.mem_we, ((i - 1) % 2) == 1);
    end
    idle();
    chk1("t6_mem_we_last", bus.mem_we, 1'b1);
    for (int i = 0; i < 5; i++) idle();
    chkw("t6_rvalid_count", 32'(rv_cnt - rv_snap), 32'd4);
    chkw("t6_last_rdata", 32'(rv_last), 32'hA003);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
